// File: rtl/mips_pkg.sv
// Shared ALU op-code encodings for the decoder and the EXE-stage ALU.
// Keeping them in one place guarantees both sides agree on every code.
package mips_pkg;

  typedef logic [5:0] alu_op_t;

  localparam alu_op_t ALU_NOP   = 6'h00;
  localparam alu_op_t ALU_ADD   = 6'h01;
  localparam alu_op_t ALU_ADDU  = 6'h02;
  localparam alu_op_t ALU_SUB   = 6'h03;
  localparam alu_op_t ALU_SUBU  = 6'h04;
  localparam alu_op_t ALU_AND   = 6'h05;
  localparam alu_op_t ALU_OR    = 6'h06;
  localparam alu_op_t ALU_XOR   = 6'h07;
  localparam alu_op_t ALU_NOR   = 6'h08;
  localparam alu_op_t ALU_SLT   = 6'h09;
  localparam alu_op_t ALU_SLTU  = 6'h0A;
  localparam alu_op_t ALU_SLL   = 6'h0B;
  localparam alu_op_t ALU_SRL   = 6'h0C;
  localparam alu_op_t ALU_SRA   = 6'h0D;
  localparam alu_op_t ALU_SLLV  = 6'h0E;
  localparam alu_op_t ALU_SRLV  = 6'h0F;
  localparam alu_op_t ALU_SRAV  = 6'h10;
  localparam alu_op_t ALU_LUI   = 6'h11;
  localparam alu_op_t ALU_MULT  = 6'h12;
  localparam alu_op_t ALU_MULTU = 6'h13;
  localparam alu_op_t ALU_DIV   = 6'h14;
  localparam alu_op_t ALU_DIVU  = 6'h15;
  localparam alu_op_t ALU_MFHI  = 6'h16;
  localparam alu_op_t ALU_MFLO  = 6'h17;
  localparam alu_op_t ALU_MTHI  = 6'h18;
  localparam alu_op_t ALU_MTLO  = 6'h19;
  localparam alu_op_t ALU_ADDR  = 6'h1A;
  localparam alu_op_t ALU_PASSB = 6'h1B;

  // HI/LO are only ever rewritten by multiply, divide and the move-to ops.
  function automatic logic writes_hilo(input alu_op_t op);
    return (op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MTHI, ALU_MTLO});
  endfunction

endpackage

// File: rtl/mips_divider.sv
// Combinational 32-bit signed/unsigned divide with remainder; zero latency.
// Signed mode truncates toward zero, remainder takes the dividend's sign.
module mips_divider (
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        div_ok,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic        ovf;

  // Divide magnitudes unsigned, then restore signs; avoids signed-divide corner semantics.
  always_comb begin
    a_neg = is_signed & a[31];
    b_neg = is_signed & b[31];
    a_mag = a_neg ? (~a + 32'd1) : a;
    b_mag = b_neg ? (~b + 32'd1) : b;
    div_ok = (b != 32'd0);
    ovf = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    q_mag = '0;
    r_mag = '0;
    if (div_ok) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem  = a_neg ? (~r_mag + 32'd1) : r_mag;
    if (ovf) begin
      quot = 32'h8000_0000;
      rem  = 32'd0;
    end
  end

endmodule

// File: rtl/mips_alu.sv
// EXE-stage integer ALU: result plus next HI/LO, fully combinational, zero latency.
// No flow control; RESET low forces a zero result and HI/LO pass-through.
module mips_alu
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       ALU_control,
  input  logic [4:0]       shiftAmount,
  input  logic [WIDTH-1:0] HI_IN,
  input  logic [WIDTH-1:0] LO_IN,
  output logic [WIDTH-1:0] aluResult,
  output logic [WIDTH-1:0] HI_OUT,
  output logic [WIDTH-1:0] LO_OUT
);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               div_signed;
  logic               div_ok;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   hi_next;
  logic [WIDTH-1:0]   lo_next;
  logic [4:0]         var_sh;

  // Sign-extended operands make the low 2*WIDTH bits of an unsigned multiply the signed product.
  assign prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  assign div_signed = (ALU_control == ALU_DIV);
  assign var_sh     = A[4:0];

  mips_divider u_div (
    .is_signed (div_signed),
    .a         (A),
    .b         (B),
    .div_ok    (div_ok),
    .quot      (quot),
    .rem       (rem)
  );

  always_comb begin
    result  = '0;
    hi_next = HI_IN;
    lo_next = LO_IN;
    case (ALU_control)
      ALU_ADD, ALU_ADDU, ALU_ADDR: result = A + B;
      ALU_SUB, ALU_SUBU:           result = A - B;
      ALU_AND:                     result = A & B;
      ALU_OR:                      result = A | B;
      ALU_XOR:                     result = A ^ B;
      ALU_NOR:                     result = ~(A | B);
      ALU_SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU:  result = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_SLL:   result = B << shiftAmount;
      ALU_SRL:   result = B >> shiftAmount;
      ALU_SRA:   result = $signed(B) >>> shiftAmount;
      ALU_SLLV:  result = B << var_sh;
      ALU_SRLV:  result = B >> var_sh;
      ALU_SRAV:  result = $signed(B) >>> var_sh;
      ALU_LUI:   result = {B[15:0], 16'h0000};
      ALU_MULT: begin
        hi_next = prod_s[2*WIDTH-1:WIDTH];
        lo_next = prod_s[WIDTH-1:0];
      end
      ALU_MULTU: begin
        hi_next = prod_u[2*WIDTH-1:WIDTH];
        lo_next = prod_u[WIDTH-1:0];
      end
      ALU_DIV, ALU_DIVU: begin
        // A zero divisor leaves HI/LO untouched rather than producing garbage.
        if (div_ok) begin
          hi_next = rem;
          lo_next = quot;
        end
      end
      ALU_MFHI:  result = HI_IN;
      ALU_MFLO:  result = LO_IN;
      ALU_MTHI:  hi_next = A;
      ALU_MTLO:  lo_next = A;
      ALU_PASSB: result = B;
      default:   result = '0;
    endcase
  end

  assign aluResult = RESET ? result : '0;
  assign HI_OUT    = (RESET && writes_hilo(ALU_control)) ? hi_next : HI_IN;
  assign LO_OUT    = (RESET && writes_hilo(ALU_control)) ? lo_next : LO_IN;

  // CLK exists only to qualify this check; the datapath itself holds no state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      assert (!$isunknown({aluResult, HI_OUT, LO_OUT}))
        else $error("mips_alu: unknown value on outputs");
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Directed bench for mips_alu: expected results queued when driven, popped and checked.
module tb_mips_alu;

  logic        CLK;
  logic        RESET;
  logic [31:0] A;
  logic [31:0] B;
  logic [5:0]  ALU_control;
  logic [4:0]  shiftAmount;
  logic [31:0] HI_IN;
  logic [31:0] LO_IN;
  logic [31:0] aluResult;
  logic [31:0] HI_OUT;
  logic [31:0] LO_OUT;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;

  mips_alu #(.WIDTH(32)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .A           (A),
    .B           (B),
    .ALU_control (ALU_control),
    .shiftAmount (shiftAmount),
    .HI_IN       (HI_IN),
    .LO_IN       (LO_IN),
    .aluResult   (aluResult),
    .HI_OUT      (HI_OUT),
    .LO_OUT      (LO_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_out();
    exp_t e;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL scoreboard: observed empty queue, expected an entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      tests++;
      assert (aluResult === e.res) else begin
        fails++;
        $error("FAIL %s.result: observed %h expected %h", e.tag, aluResult, e.res);
      end
      tests++;
      assert (HI_OUT === e.hi) else begin
        fails++;
        $error("FAIL %s.hi: observed %h expected %h", e.tag, HI_OUT, e.hi);
      end
      tests++;
      assert (LO_OUT === e.lo) else begin
        fails++;
        $error("FAIL %s.lo: observed %h expected %h", e.tag, LO_OUT, e.lo);
      end
    end
  endtask

  // Drive away from the rising edge, queue the expectation, sample 2 time units later.
  task automatic step(input string tag, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh, input logic [31:0] hi,
                      input logic [31:0] lo, input logic [31:0] e_res,
                      input logic [31:0] e_hi, input logic [31:0] e_lo);
    @(negedge CLK);
    ALU_control = op;
    A           = a;
    B           = b;
    shiftAmount = sh;
    HI_IN       = hi;
    LO_IN       = lo;
    sb.push_back('{tag, e_res, e_hi, e_lo});
    #2;
    check_out();
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    RESET       = 1'b0;
    A           = '0;
    B           = '0;
    ALU_control = '0;
    shiftAmount = '0;
    HI_IN       = '0;
    LO_IN       = '0;

    // Reset held: result forced to zero, HI/LO pass through even for a writer op.
    step("rst_add",  6'h01, 32'd5, 32'd7, 5'd0, 32'h11, 32'h22, 32'd0, 32'h11, 32'h22);
    step("rst_mult", 6'h12, 32'd4, 32'd4, 5'd0, 32'h33, 32'h44, 32'd0, 32'h33, 32'h44);

    // Release asynchronously, mid-cycle, and expect the result the same delta.
    @(negedge CLK);
    ALU_control = 6'h01;
    A = 32'd5; B = 32'd7; HI_IN = 32'h11; LO_IN = 32'h22;
    #1 RESET = 1'b1;
    sb.push_back('{"rst_release", 32'd12, 32'h11, 32'h22});
    #1;
    check_out();

    step("add_wrap", 6'h01, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h1, 32'h2, 32'h8000_0000, 32'h1, 32'h2);
    step("addr",     6'h1A, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'h1, 32'h2, 32'h1, 32'h1, 32'h2);
    step("sub",      6'h03, 32'd3, 32'd5, 5'd0, 32'h3, 32'h4, 32'hFFFF_FFFE, 32'h3, 32'h4);
    step("nor",      6'h08, 32'hF0F0_0000, 32'h0000_00FF, 5'd0, 0, 0, 32'h0F0F_FF00, 0, 0);
    step("xor",      6'h07, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 0, 0, 32'hF00F_F00F, 0, 0);
    step("slt",      6'h09, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, 0, 32'd1, 0, 0);
    step("sltu",     6'h0A, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, 0, 32'd0, 0, 0);
    step("sra4",     6'h0D, 32'd0, 32'h8000_0010, 5'd4, 0, 0, 32'hF800_0001, 0, 0);
    step("srl4",     6'h0C, 32'd0, 32'h8000_0010, 5'd4, 0, 0, 32'h0800_0001, 0, 0);
    step("sll0",     6'h0B, 32'd0, 32'h8000_0010, 5'd0, 0, 0, 32'h8000_0010, 0, 0);
    step("sllv",     6'h0E, 32'h21, 32'h8000_0010, 5'd7, 0, 0, 32'h0000_0020, 0, 0);
    step("srav",     6'h10, 32'h3F, 32'h8000_0000, 5'd0, 0, 0, 32'hFFFF_FFFF, 0, 0);
    step("lui",      6'h11, 32'd0, 32'h1234, 5'd0, 0, 0, 32'h1234_0000, 0, 0);

    step("mult",  6'h12, 32'hFFFF_FFFE, 32'd3, 5'd0, 32'h5, 32'h6, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    step("multu", 6'h13, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'h5, 32'h6, 32'd0, 32'h1, 32'hFFFF_FFFE);

    step("div_neg",  6'h14, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'h5, 32'h6, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    step("divu",     6'h15, 32'd100, 32'd7, 5'd0, 32'h5, 32'h6, 32'd0, 32'd2, 32'd14);
    step("divu_z",   6'h15, 32'd7, 32'd0, 5'd0, 32'hAA, 32'hBB, 32'd0, 32'hAA, 32'hBB);
    step("div_z",    6'h14, 32'd7, 32'd0, 5'd0, 32'hCC, 32'hDD, 32'd0, 32'hCC, 32'hDD);
    step("div_ovf",  6'h14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h5, 32'h6, 32'd0, 32'd0, 32'h8000_0000);

    step("mthi",  6'h18, 32'hDEAD, 32'h1, 5'd0, 32'h7, 32'h8, 32'd0, 32'hDEAD, 32'h8);
    step("mtlo",  6'h19, 32'hBEEF, 32'h1, 5'd0, 32'h7, 32'h8, 32'd0, 32'h7, 32'hBEEF);
    step("mfhi",  6'h16, 32'h1, 32'h2, 5'd0, 32'h66, 32'h55, 32'h66, 32'h66, 32'h55);
    step("mflo",  6'h17, 32'h1, 32'h2, 5'd0, 32'h66, 32'h55, 32'h55, 32'h66, 32'h55);
    step("passb", 6'h1B, 32'h1, 32'hCAFE_F00D, 5'd0, 32'h9, 32'hA, 32'hCAFE_F00D, 32'h9, 32'hA);
    step("nop",   6'h00, 32'h1, 32'h2, 5'd3, 32'h9, 32'hA, 32'd0, 32'h9, 32'hA);
    step("op3f",  6'h3F, 32'h1, 32'h2, 5'd3, 32'h9, 32'hA, 32'd0, 32'h9, 32'hA);

    // Asynchronous re-assert overrides a multiply that would otherwise write HI/LO.
    @(negedge CLK);
    ALU_control = 6'h13;
    A = 32'hFFFF_FFFF; B = 32'd2; HI_IN = 32'h12; LO_IN = 32'h34;
    #1 RESET = 1'b0;
    sb.push_back('{"rst_reassert", 32'd0, 32'h12, 32'h34});
    #1;
    check_out();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- Single-issue MIPS integer ALU used in the EXE pipeline stage.
- Computes one 32-bit result per cycle from forwarded operands A/B, a 6-bit op code and a 5-bit shift amount.
- Computes next HI/LO values for multiply/divide/move-to ops. The parent stage owns the HI/LO registers and latches HI_OUT/LO_OUT on its clock edge.
- Fully combinational datapath, zero latency. CLK/RESET only gate outputs during reset.

Parameters:
- WIDTH, 32, operand/result width (only 32 supported).

Ports:
- CLK  in  1  clock; the parent drives the inverted stage clock; no datapath state.
- RESET  in  1  reset, asynchronous, active-low.
- A  in  32  operand A (rs, forwarded).
- B  in  32  operand B (rt or immediate, forwarded).
- ALU_control  in  6  operation code (see Behaviour).
- shiftAmount  in  5  shamt for constant shifts.
- HI_IN  in  32  current HI register.
- LO_IN  in  32  current LO register.
- aluResult  out  32  operation result.
- HI_OUT  out  32  next HI value.
- LO_OUT  out  32  next LO value.

Behaviour:
- While RESET=0 (asynchronous, no clock needed): aluResult=0, HI_OUT=HI_IN, LO_OUT=LO_IN. After release, outputs follow inputs combinationally the same delta.
- Default for every op: HI_OUT=HI_IN, LO_OUT=LO_IN. Only codes 0x12-0x15 and 0x18-0x19 modify HI/LO.
- Op codes (hex), with aluResult unless stated:
  - 00 NOP: 0.
  - 01 ADD, 02 ADDU, 1A ADDR: A+B mod 2^32. No overflow trap.
  - 03 SUB, 04 SUBU: A-B mod 2^32.
  - 05 AND, 06 OR, 07 XOR, 08 NOR: bitwise.
  - 09 SLT: signed A<B ? 1 : 0.
  - 0A SLTU: unsigned A<B ? 1 : 0.
  - 0B SLL: B<<shiftAmount.
  - 0C SRL: B>>shiftAmount, logical.
  - 0D SRA: B>>shiftAmount, arithmetic.
  - 0E SLLV, 0F SRLV, 10 SRAV: as 0B/0C/0D, with shift count A[4:0].
  - 11 LUI: {B[15:0],16'h0}.
  - 12 MULT: signed 64-bit A*B; HI_OUT=prod[63:32], LO_OUT=prod[31:0]; aluResult=0.
  - 13 MULTU: same as MULT, unsigned.
  - 14 DIV: signed, C-style truncation toward zero. LO_OUT=quotient, HI_OUT=remainder; remainder sign follows A. aluResult=0.
  - 15 DIVU: unsigned; LO_OUT=quotient, HI_OUT=remainder.
  - 16 MFHI: HI_IN.
  - 17 MFLO: LO_IN.
  - 18 MTHI: HI_OUT=A; aluResult=0.
  - 19 MTLO: LO_OUT=A; aluResult=0.
  - 1B PASSB: B.
  - All other codes: aluResult=0, HI/LO pass through.
- Divide boundary cases:
  - B=0 (DIV or DIVU): HI_OUT=HI_IN, LO_OUT=LO_IN (unchanged).
  - DIV 0x80000000 / 0xFFFFFFFF: LO_OUT=0x80000000, HI_OUT=0.
- Shift amount 0 returns B unchanged.
- No X propagation: every output is driven for every code.

Decomposition:
- Shared package mips_pkg holds the ALU op-code localparams (ALU_NOP ... ALU_PASSB), so the decoder and EXE stage use identical encodings.
- Optional sub-module mips_divider: combinational signed/unsigned 32-bit div/rem with the zero and overflow guards above.
- Everything else stays inline in mips_alu.

Test Plan:
- Reset: RESET=0, op=ADD, A=5, B=7, HI_IN=0x11 -> aluResult=0, HI_OUT=0x11. Release RESET -> aluResult=12.
- Arithmetic and compare:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, no trap.
  - SUB 3-5 -> 0xFFFFFFFE.
  - SLT 0xFFFFFFFF vs 1 -> 1.
  - SLTU 0xFFFFFFFF vs 1 -> 0.
- Shifts and LUI (B=0x80000010):
  - SRA shamt=4 -> 0xF8000001.
  - SRL shamt=4 -> 0x08000001.
  - SLLV with A=0x21 (count 1) -> 0x00000020.
  - LUI B=0x1234 -> 0x12340000.
- Multiply:
  - MULT 0xFFFFFFFE*3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULTU 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE.
- Divide:
  - DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/0 with HI_IN=0xAA, LO_IN=0xBB -> HI/LO unchanged.
  - DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- HI/LO moves and unknown code:
  - MTHI A=0xDEAD -> HI_OUT=0xDEAD.
  - MFLO with LO_IN=0x55 -> aluResult=0x55.
  - op=0x3F -> aluResult=0, HI/LO pass through.
